// File: rtl/mips_fetch_stage_pkg.sv
// mips_fetch_stage_pkg: shared types for the MIPS-lite fetch stage
//   fetch_state_e : fetch controller states
//   HALT_OPCODE   : primary opcode that stops instruction fetch
package mips_fetch_stage_pkg;
   typedef enum logic [2:0] {IDLE, RUN, SKID, DRAIN, HALTED} fetch_state_e;
   localparam logic [5:0] HALT_OPCODE = 6'h11;
endpackage

// File: rtl/mips_fetch_stage.sv
// mips_fetch_stage: IF stage - PC, single-outstanding imem reads, skid-buffered IF/ID fetch buffer
//   clk, reset_n             : clock, async active-low reset
//   imem_req/imem_addr       : read request (combinational), 4-aligned byte address
//   imem_rdata/imem_rvalid   : in-order read response
//   stall                    : decode hold of the fetch buffer
//   redirect/redirect_pc     : taken branch/jump from execute
//   fb_valid/fb_pc/fb_instr  : IF/ID fetch buffer
//   halted                   : fetch stopped on HALT
//   fetch_count              : instructions loaded into the fetch buffer
module mips_fetch_stage
   import mips_fetch_stage_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int MEM_DEPTH = 4096,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
   input  logic clk,
   input  logic reset_n,
   output logic imem_req,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
   input  logic imem_rvalid,
   input  logic stall,
   input  logic redirect,
   input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
   output logic fb_valid,
   output logic [ADDRESS_WIDTH-1:0] fb_pc,
   output logic [INSTRUCTION_WIDTH-1:0] fb_instr,
   output logic halted,
   output logic [31:0] fetch_count
);
   localparam logic [ADDRESS_WIDTH-1:0] DEPTH = ADDRESS_WIDTH'(MEM_DEPTH);
   fetch_state_e state;
   logic [ADDRESS_WIDTH-1:0] pc;
   logic [INSTRUCTION_WIDTH-1:0] skid;
   logic accept, load, halt_hit;
   logic [ADDRESS_WIDTH-1:0] pc_inc, target;
   logic [INSTRUCTION_WIDTH-1:0] load_data;
   assign accept = !fb_valid || !stall;
   assign pc_inc = (pc + ADDRESS_WIDTH'(4)) % DEPTH;
   assign target = (redirect_pc & ~ADDRESS_WIDTH'(3)) % DEPTH;
   assign load_data = (state == SKID) ? skid : imem_rdata;
   // a redirect discards whatever would have been loaded this cycle
   assign load = !redirect && accept && ((state == RUN && imem_rvalid) || state == SKID);
   assign halt_hit = load_data[INSTRUCTION_WIDTH-1 -: 6] == HALT_OPCODE;
   // the next request goes out in the same cycle the previous one completes
   assign imem_req = !redirect && (state == IDLE || (load && !halt_hit) || (state == DRAIN && imem_rvalid));
   assign imem_addr = load ? pc_inc : pc;
   assign halted = state == HALTED;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         pc <= RESET_PC;
         skid <= '0;
         fb_valid <= 1'b0;
         fb_pc <= '0;
         fb_instr <= '0;
         fetch_count <= '0;
      end else if (redirect) begin
         pc <= target;
         fb_valid <= 1'b0;
         // a request still in flight must have its response swallowed
         state <= ((state == RUN || state == DRAIN) && !imem_rvalid) ? DRAIN : IDLE;
      end else if (load) begin
         fb_valid <= 1'b1;
         fb_pc <= pc;
         fb_instr <= load_data;
         fetch_count <= fetch_count + 32'd1;
         state <= halt_hit ? HALTED : RUN;
         if (!halt_hit) pc <= pc_inc;
      end else begin
         if (!stall) fb_valid <= 1'b0;
         case (state)
            IDLE: state <= RUN;
            RUN: if (imem_rvalid) begin
               skid <= imem_rdata;
               state <= SKID;
            end
            DRAIN: if (imem_rvalid) state <= RUN;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mips_fetch_stage.sv
// tb_mips_fetch_stage: directed checks of the fetch stage against a latency-1/2 memory model
module tb_mips_fetch_stage;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic imem_rvalid;
   logic stall = 1'b0;
   logic redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic fb_valid;
   logic [31:0] fb_pc;
   logic [31:0] fb_instr;
   logic halted;
   logic [31:0] fetch_count;
   int total = 0;
   int passed = 0;
   logic lat1 = 1'b1;
   logic d1_v;
   logic [31:0] d1_a;
   logic [31:0] mem [0:1023];

   mips_fetch_stage dut (
      .clk(clk), .reset_n(reset_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .fb_valid(fb_valid), .fb_pc(fb_pc), .fb_instr(fb_instr),
      .halted(halted), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   // word i holds {i[5:0], i[25:0]}; opcode 0x11 is replaced by 0x12 except the planted HALT at 0x10
   initial begin
      for (int i = 0; i < 1024; i++) begin
         logic [5:0] op;
         op = 6'(i);
         if (op == 6'h11) op = 6'h12;
         mem[i] = {op, 26'(i)};
      end
      mem[4] = 32'h4400_0000;
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         imem_rvalid <= 1'b0;
         imem_rdata <= '0;
         d1_v <= 1'b0;
         d1_a <= '0;
      end else begin
         imem_rvalid <= d1_v | (imem_req & lat1);
         imem_rdata <= d1_v ? mem[d1_a[11:2]] : mem[imem_addr[11:2]];
         d1_v <= imem_req & !lat1;
         d1_a <= imem_addr;
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      step();
      total++; if (fb_valid !== 1'b0) $display("FAIL reset_fb_valid got %h want 0", fb_valid); else passed++;
      total++; if (fb_pc !== 32'h0) $display("FAIL reset_fb_pc got %h want 0", fb_pc); else passed++;
      total++; if (fb_instr !== 32'h0) $display("FAIL reset_fb_instr got %h want 0", fb_instr); else passed++;
      total++; if (fetch_count !== 32'h0) $display("FAIL reset_count got %h want 0", fetch_count); else passed++;
      total++; if (halted !== 1'b0) $display("FAIL reset_halted got %h want 0", halted); else passed++;
      total++; if (imem_req !== 1'b1) $display("FAIL reset_req got %h want 1", imem_req); else passed++;
      total++; if (imem_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", imem_addr); else passed++;
      step();
      reset_n = 1'b1;
   endtask

   task automatic test_stream();
      step();
      total++; if (fb_valid !== 1'b0) $display("FAIL stream_c1_valid got %h want 0", fb_valid); else passed++;
      total++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) $display("FAIL stream_c1_req got %h/%h want 1/4", imem_req, imem_addr); else passed++;
      step();
      total++; if (fb_valid !== 1'b1 || fb_pc !== 32'h0) $display("FAIL stream_c2 got %h/%h want 1/0", fb_valid, fb_pc); else passed++;
      total++; if (fetch_count !== 32'd1) $display("FAIL stream_c2_count got %0d want 1", fetch_count); else passed++;
      step();
      total++; if (fb_pc !== 32'h4 || fb_instr !== 32'h0400_0001) $display("FAIL stream_c3 got %h/%h want 4/04000001", fb_pc, fb_instr); else passed++;
      total++; if (fetch_count !== 32'd2) $display("FAIL stream_c3_count got %0d want 2", fetch_count); else passed++;
      step();
      total++; if (fb_pc !== 32'h8 || fb_instr !== 32'h0800_0002) $display("FAIL stream_c4 got %h/%h want 8/08000002", fb_pc, fb_instr); else passed++;
      total++; if (fetch_count !== 32'd3) $display("FAIL stream_c4_count got %0d want 3", fetch_count); else passed++;
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         total++; if (fb_valid !== 1'b1 || fb_pc !== 32'h8) $display("FAIL stall_hold%0d got %h/%h want 1/8", c, fb_valid, fb_pc); else passed++;
         total++; if (imem_req !== 1'b0) $display("FAIL stall_noreq%0d got %h want 0", c, imem_req); else passed++;
      end
      total++; if (fetch_count !== 32'd3) $display("FAIL stall_count got %0d want 3", fetch_count); else passed++;
      stall = 1'b0;
      #1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) $display("FAIL stall_release_req got %h/%h want 1/10", imem_req, imem_addr); else passed++;
      step();
      total++; if (fb_pc !== 32'hC || fb_instr !== 32'h0C00_0003) $display("FAIL stall_skid_out got %h/%h want c/0c000003", fb_pc, fb_instr); else passed++;
   endtask

   task automatic test_halt();
      total++; if (imem_req !== 1'b0) $display("FAIL halt_noreq got %h want 0", imem_req); else passed++;
      step();
      total++; if (halted !== 1'b1 || fb_valid !== 1'b1) $display("FAIL halt_enter got %h/%h want 1/1", halted, fb_valid); else passed++;
      total++; if (fb_pc !== 32'h10 || fb_instr !== 32'h4400_0000) $display("FAIL halt_fb got %h/%h want 10/44000000", fb_pc, fb_instr); else passed++;
      step();
      total++; if (fb_valid !== 1'b0 || halted !== 1'b1) $display("FAIL halt_drain got %h/%h want 0/1", fb_valid, halted); else passed++;
      total++; if (imem_req !== 1'b0 || fb_pc !== 32'h10) $display("FAIL halt_idle got %h/%h want 0/10", imem_req, fb_pc); else passed++;
      total++; if (fetch_count !== 32'd5) $display("FAIL halt_count got %0d want 5", fetch_count); else passed++;
   endtask

   task automatic test_wrap_resume();
      redirect = 1'b1;
      redirect_pc = 32'h1FFE;
      step();
      redirect = 1'b0;
      #1;
      total++; if (halted !== 1'b0) $display("FAIL resume_halted got %h want 0", halted); else passed++;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFC) $display("FAIL resume_req got %h/%h want 1/ffc", imem_req, imem_addr); else passed++;
      step();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL wrap_addr got %h/%h want 1/0", imem_req, imem_addr); else passed++;
      step();
      total++; if (fb_pc !== 32'hFFC || fb_instr !== 32'hFC00_03FF) $display("FAIL wrap_fb got %h/%h want ffc/fc0003ff", fb_pc, fb_instr); else passed++;
      total++; if (fetch_count !== 32'd6) $display("FAIL wrap_count got %0d want 6", fetch_count); else passed++;
   endtask

   task automatic test_redirect_same_cycle();
      redirect = 1'b1;
      redirect_pc = 32'h203;
      #1;
      total++; if (imem_req !== 1'b0) $display("FAIL redir_noreq got %h want 0", imem_req); else passed++;
      step();
      redirect = 1'b0;
      #1;
      total++; if (fb_valid !== 1'b0 || fetch_count !== 32'd6) $display("FAIL redir_discard got %h/%0d want 0/6", fb_valid, fetch_count); else passed++;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) $display("FAIL redir_target got %h/%h want 1/200", imem_req, imem_addr); else passed++;
      step();
      total++; if (fb_valid !== 1'b0) $display("FAIL redir_bubble got %h want 0", fb_valid); else passed++;
      step();
      total++; if (fb_valid !== 1'b1 || fb_pc !== 32'h200 || fb_instr !== 32'h0000_0080) $display("FAIL redir_fb got %h/%h/%h want 1/200/00000080", fb_valid, fb_pc, fb_instr); else passed++;
      total++; if (fetch_count !== 32'd7) $display("FAIL redir_count got %0d want 7", fetch_count); else passed++;
   endtask

   task automatic test_redirect_drain();
      lat1 = 1'b0;
      step();
      total++; if (fb_pc !== 32'h204 || imem_req !== 1'b0) $display("FAIL drain_pre got %h/%h want 204/0", fb_pc, imem_req); else passed++;
      redirect = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      #1;
      total++; if (fb_valid !== 1'b0) $display("FAIL drain_flush got %h want 0", fb_valid); else passed++;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) $display("FAIL drain_req got %h/%h want 1/100", imem_req, imem_addr); else passed++;
      step();
      total++; if (fb_valid !== 1'b0 || fetch_count !== 32'd8) $display("FAIL drain_stale got %h/%0d want 0/8", fb_valid, fetch_count); else passed++;
      total++; if (imem_req !== 1'b0) $display("FAIL drain_wait got %h want 0", imem_req); else passed++;
      step();
      total++; if (fb_valid !== 1'b0) $display("FAIL drain_bubble got %h want 0", fb_valid); else passed++;
      step();
      total++; if (fb_valid !== 1'b1 || fb_pc !== 32'h100 || fb_instr !== 32'h0000_0040) $display("FAIL drain_fb got %h/%h/%h want 1/100/00000040", fb_valid, fb_pc, fb_instr); else passed++;
   endtask

   task automatic test_redirect_stall();
      stall = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h300;
      step();
      stall = 1'b0;
      redirect = 1'b0;
      #1;
      total++; if (fb_valid !== 1'b0 || fetch_count !== 32'd9) $display("FAIL rs_flush got %h/%0d want 0/9", fb_valid, fetch_count); else passed++;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) $display("FAIL rs_req got %h/%h want 1/300", imem_req, imem_addr); else passed++;
      step();
      step();
      total++; if (fb_valid !== 1'b0) $display("FAIL rs_bubble got %h want 0", fb_valid); else passed++;
      step();
      total++; if (fb_valid !== 1'b1 || fb_pc !== 32'h300 || fb_instr !== 32'h0000_00C0) $display("FAIL rs_fb got %h/%h/%h want 1/300/000000c0", fb_valid, fb_pc, fb_instr); else passed++;
      total++; if (fetch_count !== 32'd10) $display("FAIL rs_count got %0d want 10", fetch_count); else passed++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_halt();
      test_wrap_resume();
      test_redirect_same_cycle();
      test_redirect_drain();
      test_redirect_stall();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
